hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Hazard/forwarding controller for the 5-stage RV32I pipeline, directly upstream of the EX-stage
//  operand muxes. Keeps its own shadow of in-flight destinations (EX, MEM, WB slots).
//  Produces registered 2-bit forward selects valid during each instruction's EX cycle.
//  Detects load-use hazards and issues a 1-cycle stall with bubble insertion.
// PARAMETERS
//  REG_W   5   register index width
//  CNT_W   16  width of stall performance counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  id_valid      in   1      ID stage holds a real instruction
//  id_rs1        in   REG_W  ID source register 1
//  id_rs2        in   REG_W  ID source register 2
//  id_rd         in   REG_W  ID destination register
//  id_regwrite   in   1      ID instruction writes rd
//  id_memread    in   1      ID instruction is a load
//  flush         in   1      branch/jump taken in EX: kill the instruction in ID
//  fwd_a         out  2      EX operand-A select: 00 ID/EX value, 01 MEM/WB, 10 EX/MEM
//  fwd_b         out  2      EX operand-B select, same encoding
//  stall         out  1      comb: hold PC and IF/ID, bubble into ID/EX this cycle
//  stall_count   out  CNT_W  number of stall cycles since reset, saturating
// BEHAVIOUR
//  - State: slots EX, MEM and WB, each {valid, rd, regwrite, memread}; fwd_a/fwd_b regs; counter.
//  - Reset (async): all slot valid=0, fwd_a=fwd_b=2'b00, stall_count=0; stall then reads 0.
//  - match(s,r) = s.valid & s.regwrite & (s.rd!=0) & (s.rd==r); x0 never matches.
//  - stall = id_valid & EX.valid & EX.memread & (match(EX,id_rs1) | match(EX,id_rs2)) & ~flush.
//  - Each posedge, priority flush > stall > normal:
//      WB<=MEM, MEM<=EX always (the pipeline never freezes past ID/EX).
//      flush : EX<=bubble (valid=0), fwd_a=fwd_b<=00.
//      stall : EX<=bubble, fwd_a=fwd_b<=00, stall_count+=1 (hold at all-ones).
//      normal: EX<={id_valid,id_rd,id_regwrite,id_memread};
//              fwd_x<= match(EX,id_rsx) ? 10 : match(MEM,id_rsx) ? 01 : 00 (EX slot wins).
//      If id_valid=0 in the normal case: EX<=bubble and fwd_x<=00.
//  - Latency: fwd_x is registered; it is valid in the cycle the instruction occupies EX.
//  - Select 11 is never produced.
//  - Register file is write-through, so a WB-slot producer needs no forward.
//  - After a load-use stall the load sits in MEM when the consumer enters EX, which gives fwd=01.
//  - Back-to-back loads: the stall rule is evaluated every cycle. A stall lasts at most 1 cycle
//    per hazard because the bubble clears the EX slot.
//  - Reset asserted mid-stall: all slots are cleared at once; no pending stall survives.
// TESTING
//  1 add x5 then add x6,x5,x1 back-to-back -> next cycle fwd_a=10, fwd_b=00, stall=0.
//  2 add x5; nop; sub x7,x1,x5 -> sub in EX with fwd_b=01, fwd_a=00.
//  3 lw x5 then add x6,x5,x5 -> stall=1 for exactly 1 cycle, stall_count 0->1;
//    add then enters EX with fwd_a=fwd_b=01.
//  4 producer rd=x0 (addi x0,..) followed by consumer of x0 -> fwd=00, no stall.
//  5 lw x5 then add x6,x5,x1 with flush=1 in the same cycle -> stall=0, EX bubble,
//    fwd=00, count unchanged.
//  6 rst pulsed asynchronously mid-stall -> outputs 00/0/0 immediately; then 2^CNT_W+3
//    forced stalls -> stall_count saturates at all-ones.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Load-use hazard detection and EX operand forward-select generation for a 5-stage RV32I pipeline.
// Tracks in-flight destinations in its own EX/MEM shadow slots and registers the forward selects.
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_EX   = 2'b10;

  // The WB slot is not shadowed: the register file is write-through, so a
  // producer in WB never needs a forward and its state would have no reader.
  slot_t            ex_q, ex_d, mem_q;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  function automatic logic match(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r);
  endfunction

  function automatic logic [1:0] sel(input slot_t ex, input slot_t mem,
                                     input logic [REG_W-1:0] r);
    if (match(ex, r))       return FWD_EX;
    else if (match(mem, r)) return FWD_MEM;
    else                    return FWD_NONE;
  endfunction

  assign stall = id_valid_i & ex_q.valid & ex_q.memread &
                 (match(ex_q, id_rs1_i) | match(ex_q, id_rs2_i)) & ~flush_i;

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    cnt_d   = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (id_valid_i) begin
      ex_d    = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
      fwd_a_d = sel(ex_q, mem_q, id_rs1_i);
      fwd_b_d = sel(ex_q, mem_q, id_rs2_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
      cnt_q   <= '0;
    end else begin
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_o       = fwd_a_q;
  assign fwd_b_o       = fwd_b_q;
  assign stall_o       = stall;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: cycle-by-cycle vector table plus reset and saturation sequences.
module tb_hazard_forward_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic             id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .flush_i(flush), .fwd_a_o(fwd_a),
    .fwd_b_o(fwd_b), .stall_o(stall), .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v, rs1, rs2, rd, rw, mr, fl;
    int st, fa, fb, cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(int v, int rs1, int rs2, int rd, int rw, int mr, int fl,
                              int st, int fa, int fb, int cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl;
    r.st = st; r.fa = fa; r.fb = fb; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int rs1, input int rs2, input int rd,
                       input int rw, input int mr, input int fl);
    id_valid    = v[0];
    id_rs1      = rs1[REG_W-1:0];
    id_rs2      = rs2[REG_W-1:0];
    id_rd       = rd[REG_W-1:0];
    id_regwrite = rw[0];
    id_memread  = mr[0];
    flush       = fl[0];
  endtask

  initial begin
    // Each row is one ID cycle; expected fwd/cnt are the values right after that edge.
    tbl[0]  = mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0); // add x5,x1,x2
    tbl[1]  = mk(1, 5, 1, 6, 1, 0, 0,  0, 2, 0, 0); // add x6,x5,x1 -> EX fwd on A
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // nop
    tbl[3]  = mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0); // add x5,x1,x2
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // nop
    tbl[5]  = mk(1, 1, 5, 7, 1, 0, 0,  0, 0, 1, 0); // sub x7,x1,x5 -> MEM fwd on B
    tbl[6]  = mk(1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0); // addi x0,x1,0
    tbl[7]  = mk(1, 0, 0, 8, 1, 0, 0,  0, 0, 0, 0); // add x8,x0,x0 -> x0 never forwards
    tbl[8]  = mk(1, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0); // lw x5,0(x1)
    tbl[9]  = mk(1, 5, 5, 6, 1, 0, 0,  1, 0, 0, 1); // add x6,x5,x5 -> stall
    tbl[10] = mk(1, 5, 5, 6, 1, 0, 0,  0, 1, 1, 1); // held add -> MEM fwd both
    tbl[11] = mk(1, 1, 0, 5, 1, 1, 0,  0, 0, 0, 1); // lw x5,0(x1)
    tbl[12] = mk(1, 5, 1, 6, 1, 0, 1,  0, 0, 0, 1); // add x6,x5,x1 with flush
    tbl[13] = mk(1, 5, 6, 9, 1, 0, 0,  0, 1, 0, 1); // add x9,x5,x6 -> lw in MEM
    tbl[14] = mk(1, 9, 5, 9, 1, 0, 0,  0, 2, 0, 1); // add x9,x9,x5
    tbl[15] = mk(1, 9, 9, 10, 1, 0, 0, 0, 2, 2, 1); // both slots x9: EX wins
    tbl[16] = mk(1, 1, 0, 3, 1, 1, 0,  0, 0, 0, 1); // lw x3,0(x1)
    tbl[17] = mk(1, 3, 0, 4, 1, 1, 0,  1, 0, 0, 2); // lw x4,0(x3) -> stall
    tbl[18] = mk(1, 3, 0, 4, 1, 1, 0,  0, 1, 0, 2);
    tbl[19] = mk(1, 4, 0, 11, 1, 0, 0, 1, 0, 0, 3); // add x11,x4,x0 -> stall
    tbl[20] = mk(1, 4, 0, 11, 1, 0, 0, 0, 1, 0, 3);

    #2;
    chk("reset fwd_a", fwd_a, 0);
    chk("reset fwd_b", fwd_b, 0);
    chk("reset stall", stall, 0);
    chk("reset count", stall_count, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #2;
      chk($sformatf("row%0d stall", i), stall, tbl[i].st);
      @(posedge clk); #1;
      chk($sformatf("row%0d fwd_a", i), fwd_a, tbl[i].fa);
      chk($sformatf("row%0d fwd_b", i), fwd_b, tbl[i].fb);
      chk($sformatf("row%0d count", i), stall_count, tbl[i].cnt);
    end

    // Async reset in the middle of a load-use stall.
    drive(1, 11, 0, 5, 1, 1, 0);               // lw x5,0(x11): EX fwd on A
    #2; chk("pre-rst stall", stall, 0);
    @(posedge clk); #1;
    chk("pre-rst fwd_a", fwd_a, 2);
    drive(1, 5, 5, 6, 1, 0, 0);                // add x6,x5,x5
    #2; chk("mid-stall stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("async rst fwd_a", fwd_a, 0);
    chk("async rst stall", stall, 0);
    chk("async rst count", stall_count, 0);
    rst = 1'b0;
    #1; chk("post-rst stall", stall, 0);
    @(posedge clk); #1;
    chk("post-rst count", stall_count, 0);

    // Repeated load-use stalls drive the counter into saturation.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1, 0, 0, 5, 1, 1, 0);              // lw x5,0(x0)
      #2; chk($sformatf("sat%0d load stall", i), stall, 0);
      @(posedge clk); #1;
      drive(1, 5, 5, 6, 1, 0, 0);              // add x6,x5,x5
      #2; chk($sformatf("sat%0d stall", i), stall, 1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d count", i), stall_count,
          (i + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : i + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
